// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared, tagged ALU.
// Issues tagged ops and routes keyed results back to their requesters.
`ifndef PID_RES
`define PID_RES 16
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 3
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 4
`endif

module alu_arbiter #(
  parameter int nbits = `PID_RES,
  parameter int NREQ  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [NREQ*`OPCODE_SIZE-1:0] req_op_i,
  input  logic [NREQ*nbits-1:0]       req_A_i,
  input  logic [NREQ*nbits-1:0]       req_B_i,
  output logic [NREQ-1:0]             rsp_valid_o,
  output logic [nbits-1:0]            rsp_data_o,
  output logic                        err_o,
  output logic [`KEY_SIZE-1:0]        alu_key_o,
  output logic [`OPCODE_SIZE-1:0]     alu_op_o,
  output logic [nbits-1:0]            alu_A_o,
  output logic [nbits-1:0]            alu_B_o,
  input  logic [`KEY_SIZE-1:0]        alu_key_i,
  input  logic [nbits-1:0]            alu_O_i
);

  localparam int KW = `KEY_SIZE;
  localparam int OW = `OPCODE_SIZE;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] pending_nxt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] hit;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   hi;
  logic [PW-1:0]   lo;
  logic            hi_v;
  logic            lo_v;
  logic            accept;
  logic            bad;
  logic [OW-1:0]   op_sel;
  logic [nbits-1:0] a_sel;
  logic [nbits-1:0] b_sel;

  assign elig = req_valid_i & ~pending;

  // Lowest eligible index at or above ptr wins; otherwise wrap to lowest.
  always_comb begin
    hi   = '0;
    lo   = '0;
    hi_v = 1'b0;
    lo_v = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_v = 1'b1;
        lo   = PW'(i);
        if (i >= int'(ptr)) begin
          hi_v = 1'b1;
          hi   = PW'(i);
        end
      end
    end
  end

  assign gnt    = hi_v ? hi : lo;
  assign accept = en & lo_v;

  assign ptr_nxt = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);

  always_comb begin
    req_ready_o = '0;
    op_sel      = '0;
    a_sel       = '0;
    b_sel       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == PW'(i)) begin
        req_ready_o[i] = accept;
        op_sel = req_op_i[i*OW +: OW];
        a_sel  = req_A_i[i*nbits +: nbits];
        b_sel  = req_B_i[i*nbits +: nbits];
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NREQ; i++) begin
      hit[i] = pending[i] & (alu_key_i == KW'(i + 1));
    end
  end

  assign bad = (alu_key_i != '0) & ~(|hit);

  assign pending_nxt = (pending & ~hit) | req_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      ptr         <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
      alu_key_o   <= '0;
      alu_op_o    <= '0;
      alu_A_o     <= '0;
      alu_B_o     <= '0;
    end else if (clr) begin
      pending     <= '0;
      ptr         <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      err_o       <= 1'b0;
      alu_key_o   <= '0;
      alu_op_o    <= '0;
      alu_A_o     <= '0;
      alu_B_o     <= '0;
    end else begin
      pending     <= pending_nxt;
      rsp_valid_o <= hit;
      if (|hit) begin
        rsp_data_o <= alu_O_i;
      end
      if (bad) begin
        err_o <= 1'b1;
      end
      alu_key_o <= accept ? KW'(gnt) + KW'(1) : '0;
      if (accept) begin
        alu_op_o <= op_sel;
        alu_A_o  <= a_sel;
        alu_B_o  <= b_sel;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and
// round-robin reference model.
`ifndef PID_RES
`define PID_RES 16
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 3
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 4
`endif

module tb_alu_arbiter;
  localparam int NB = 16;
  localparam int NR = 4;
  localparam int KW = `KEY_SIZE;
  localparam int OW = `OPCODE_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b0;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic [NR*OW-1:0] req_op_i = '0;
  logic [NR*NB-1:0] req_A_i = '0;
  logic [NR*NB-1:0] req_B_i = '0;
  logic [NR-1:0]    rsp_valid_o;
  logic [NB-1:0]    rsp_data_o;
  logic             err_o;
  logic [KW-1:0]    alu_key_o;
  logic [OW-1:0]    alu_op_o;
  logic [NB-1:0]    alu_A_o;
  logic [NB-1:0]    alu_B_o;
  logic [KW-1:0]    alu_key_i = '0;
  logic [NB-1:0]    alu_O_i = '0;

  always #5 clk = ~clk;

  alu_arbiter #(.nbits(NB), .NREQ(NR)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_A_i(req_A_i), .req_B_i(req_B_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .err_o(err_o), .alu_key_o(alu_key_o), .alu_op_o(alu_op_o),
    .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
    .alu_key_i(alu_key_i), .alu_O_i(alu_O_i)
  );

  typedef struct { int key; int op; int a; int b; } iss_t;
  typedef struct { int idx; int data; } rsp_t;
  typedef struct { int key; int data; int due; } fl_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  fl_t  fl[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int mptr = 0;
  bit pend[NR];
  bit exp_err = 0;
  int op_r[NR];
  int a_r[NR];
  int b_r[NR];
  int lat_r[NR];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int alu_fn(int op, int a, int b);
    int r;
    case (op % 4)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a ^ b;
      default: r = a & b;
    endcase
    return r & 16'hffff;
  endfunction

  function automatic void new_req(int i);
    op_r[i] = $urandom_range(0, 3);
    a_r[i]  = $urandom_range(0, 65535);
    b_r[i]  = $urandom_range(0, 65535);
  endfunction

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      req_op_i[i*OW +: OW] = OW'(op_r[i]);
      req_A_i[i*NB +: NB]  = NB'(a_r[i]);
      req_B_i[i*NB +: NB]  = NB'(b_r[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) pend[i] = 0;
    mptr = 0;
    exp_err = 0;
    iss_q.delete();
    rsp_q.delete();
  endtask

  // One cycle: ALU model response, grant prediction, model update.
  task automatic step(input logic [NR-1:0] v, input bit e, input int fkey);
    int k, d, g, pick, hit, lat, ix;
    @(negedge clk);
    cyc++;
    req_valid_i = v;
    en = e;
    pack();
    k = 0;
    d = 0;
    pick = -1;
    if (fkey != 0) begin
      k = fkey;
      d = $urandom_range(0, 65535);
    end else begin
      foreach (fl[j])
        if (fl[j].due <= cyc && (pick < 0 || fl[j].due < fl[pick].due))
          pick = j;
      if (pick >= 0) begin
        k = fl[pick].key;
        d = fl[pick].data;
        fl.delete(pick);
      end
    end
    alu_key_i = KW'(k);
    alu_O_i = NB'(d);
    hit = -1;
    if (k != 0) begin
      if (k <= NR && pend[k-1]) begin
        hit = k - 1;
        rsp_q.push_back('{hit, d});
      end else begin
        exp_err = 1;
      end
    end
    #1;
    g = -1;
    if (e) begin
      for (int off = 0; off < NR; off++) begin
        ix = (mptr + off) % NR;
        if (g < 0 && v[ix] && !pend[ix]) g = ix;
      end
    end
    chk("ready", 64'(req_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("ready_onehot", 64'($onehot0(req_ready_o)), 64'd1);
    if (g >= 0) begin
      iss_q.push_back('{g + 1, op_r[g], a_r[g], b_r[g]});
      lat = (lat_r[g] > 0) ? lat_r[g] : $urandom_range(1, 6);
      fl.push_back('{g + 1, alu_fn(op_r[g], a_r[g], b_r[g]), cyc + lat});
      pend[g] = 1;
      mptr = (g + 1) % NR;
      new_req(g);
    end
    if (hit >= 0) pend[hit] = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (fl.size() > 0 && n < 100) begin
      step('0, 1'b1, 0);
      n++;
    end
    chk("drain_timeout", 64'(fl.size()), 64'd0);
    step('0, 1'b1, 0);
    step('0, 1'b1, 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    req_valid_i = '0;
    alu_key_i = '0;
    clr = 1'b1;
    clear_model();
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid_i = '0;
    alu_key_i = '0;
    #2 rst = 1'b0;
    #1;
    chk("async_reset_zero",
        64'({alu_key_o, alu_op_o, alu_A_o, alu_B_o}), 64'd0);
    chk("async_reset_rsp",
        64'({rsp_valid_o, rsp_data_o, err_o}), 64'd0);
    clear_model();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: pops expected issues/responses whenever the DUT presents one.
  initial begin
    iss_t ei;
    rsp_t er;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (alu_key_o != '0 || iss_q.size() > 0) begin
          if (iss_q.size() == 0) begin
            chk("issue_spurious", 64'(alu_key_o), 64'd0);
          end else begin
            ei = iss_q.pop_front();
            chk("issue", 64'({alu_key_o, alu_op_o, alu_A_o, alu_B_o}),
                64'({KW'(ei.key), OW'(ei.op), NB'(ei.a), NB'(ei.b)}));
          end
        end
        if (rsp_valid_o != '0 || rsp_q.size() > 0) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_spurious", 64'(rsp_valid_o), 64'd0);
          end else begin
            er = rsp_q.pop_front();
            chk("rsp", 64'({rsp_valid_o, rsp_data_o}),
                64'({NR'(1) << er.idx, NB'(er.data)}));
          end
        end
        chk("err", 64'(err_o), 64'(exp_err));
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      new_req(i);
      lat_r[i] = 0;
      pend[i] = 0;
    end
    pack();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // idle after reset
    repeat (5) step('0, 1'b1, 0);

    // single requester 2: ADD 5+7, ALU latency 3
    op_r[2] = 0;
    a_r[2] = 5;
    b_r[2] = 7;
    lat_r[2] = 3;
    step(4'b0100, 1'b1, 0);
    lat_r[2] = 0;
    drain();

    // out-of-order: key 2 returns before key 1
    lat_r[0] = 4;
    lat_r[1] = 1;
    step(4'b0011, 1'b1, 0);
    step(4'b0011, 1'b1, 0);
    lat_r[0] = 0;
    lat_r[1] = 0;
    drain();

    // all four continuously valid, latency 1
    for (int i = 0; i < NR; i++) lat_r[i] = 1;
    repeat (20) step(4'b1111, 1'b1, 0);
    for (int i = 0; i < NR; i++) lat_r[i] = 0;
    drain();

    // bad keys: unpending key 3, out-of-range key 7; sticky until clr
    step('0, 1'b1, 3);
    step('0, 1'b1, 7);
    repeat (3) step('0, 1'b1, 0);
    do_clr();
    repeat (2) step('0, 1'b1, 0);

    // randomized traffic with en toggling
    repeat (400) step(NR'($urandom), ($urandom_range(0, 9) != 0), 0);
    drain();
    do_clr();
    repeat (2) step('0, 1'b1, 0);

    // reset with two operations in flight
    lat_r[0] = 20;
    lat_r[1] = 20;
    repeat (3) step(4'b0011, 1'b1, 0);
    lat_r[0] = 0;
    lat_r[1] = 0;
    do_reset();
    drain();
    repeat (2) step(4'b0101, 1'b1, 0);
    drain();

    chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
